dp_result_buffer: RTL and testbench
===================================

// Module: dp_result_buffer
// PURPOSE
//  Elastic output stage fed by the generated signed datapath (SADD/SSUB/SMUL/REG netlist).
//  Captures each registered result pair {x (16b signed), z (8b)} into a small FIFO.
//  Presents pairs downstream on a valid/ready handshake, decoupling datapath issue rate from the consumer.
//  Flags any result lost while the buffer is full.
// PARAMETERS
//  XWIDTH  16  width of signed result x (matches REG output width)
//  ZWIDTH  8   width of result z (mux output width)
//  DEPTH   4   FIFO entries; power of two, >= 2
// PORTS
//  CLK        in   1               rising-edge clock
//  RST        in   1               asynchronous, active-high reset
//  in_valid   in   1               upstream result pair valid this cycle
//  x_in       in   XWIDTH          signed result x
//  z_in       in   ZWIDTH          result z
//  in_ready   out  1               buffer can accept a pair this cycle
//  out_valid  out  1               head entry valid
//  x_out      out  XWIDTH          head entry x
//  z_out      out  ZWIDTH          head entry z
//  out_ready  in   1               downstream accepts head this cycle
//  count      out  $clog2(DEPTH)+1 number of occupied entries, 0..DEPTH
//  ovf        out  1               sticky: a pair was offered while full
//  acc_out    out  XWIDTH+8        signed running sum of popped x values (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (RST=1, async): count=0, rd/wr pointers=0, ovf=0, acc_out=0.
//    Outputs settle to out_valid=0, x_out=0, z_out=0, in_ready=1.
//    Storage array contents are not reset.
//  - push = in_valid & in_ready; pop = out_valid & out_ready; both evaluated at the CLK rising edge.
//  - in_ready = (count != DEPTH); depends only on registered count, never on out_ready.
//    A full buffer refuses a push even when a pop occurs in the same cycle.
//  - out_valid = (count != 0).
//    x_out/z_out = entry at rd_ptr when out_valid, else forced to 0 (no stale data visible).
//  - Latency: a pair pushed into an empty buffer is visible at out_valid/x_out/z_out the next cycle.
//    No same-cycle bypass.
//  - Push writes mem[wr_ptr] and advances wr_ptr; pop advances rd_ptr.
//    Pointers wrap modulo DEPTH (log2(DEPTH) bits).
//  - Count update: push only: count+1; pop only: count-1; push and pop together: count unchanged, both pointers advance.
//  - Order is strictly FIFO. Data is stored unmodified; x keeps its two's-complement value.
//  - ovf is set at the edge where in_valid=1 and in_ready=0. It stays set until RST. The offered pair is discarded.
//  - Held handshake: if out_ready=0, the head entry and out_valid hold stable until popped.
//  - RST asserted mid-operation discards all entries immediately. The in-flight push/pop in that cycle is lost.
// CONFIGURATION
//  Macro DP_RESULT_ACC_EN.
//  - Defined: on every pop, acc_out <= acc_out + sign_extend(x_out, XWIDTH+8).
//    The sum wraps modulo 2^(XWIDTH+8) with no saturation; the update takes effect the cycle after the pop.
//  - Not defined: acc_out is tied to 0 and no accumulator logic is built.
//  - FIFO behaviour is identical in both builds.
// TESTING
//  1. Reset, then push x=16'h0005,z=8'h03 with out_ready=0.
//     Next cycle: out_valid=1, x_out=0005, z_out=03, count=1.
//  2. Push 4 pairs x=1,2,3,4 with out_ready=0.
//     count=4, in_ready=0. A 5th push (x=5) sets ovf=1 and count stays 4.
//     Popping then yields 1,2,3,4 in order; ovf stays 1.
//  3. Full buffer, in_valid=1 and out_ready=1 on the same cycle.
//     Pop occurs, push is refused, count=3, in_ready=1 next cycle.
//  4. count=2, continuous push and pop for 10 cycles. count stays 2, order is preserved, pointers wrap correctly.
//  5. With DP_RESULT_ACC_EN, pop x=16'hFFFE(-2), then 16'h0007.
//     acc_out = -2 (24'hFFFFFE), then 24'h000005. Without the macro, acc_out stays 0.
//  6. Assert RST with count=3 mid-stream.
//     Immediately: out_valid=0, x_out=0, count=0, ovf=0, in_ready=1.

Source files
------------

// File: rtl/dp_result_buffer.sv
// Elastic FIFO for datapath {x,z} result pairs with sticky overflow flag.
// Optional popped-x accumulator is built when DP_RESULT_ACC_EN is defined.
module dp_result_buffer #(
  parameter int XWIDTH = 16,
  parameter int ZWIDTH = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       in_valid,
  input  logic [XWIDTH-1:0]          x_in,
  input  logic [ZWIDTH-1:0]          z_in,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [XWIDTH-1:0]          x_out,
  output logic [ZWIDTH-1:0]          z_out,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf,
  output logic [XWIDTH+7:0]          acc_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [XWIDTH-1:0] xmem [DEPTH];
  logic [ZWIDTH-1:0] zmem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push;
  logic              pop;

  // in_ready looks only at registered count, so full refuses even on a pop
  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign x_out     = out_valid ? xmem[rd_ptr] : '0;
  assign z_out     = out_valid ? zmem[rd_ptr] : '0;

  always_ff @(posedge CLK) begin
    if (push) begin
      xmem[wr_ptr] <= x_in;
      zmem[wr_ptr] <= z_in;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (in_valid && !in_ready)
        ovf <= 1'b1;
    end
  end

`ifdef DP_RESULT_ACC_EN
  logic [XWIDTH+7:0] acc_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      acc_q <= '0;
    else if (pop)
      acc_q <= acc_q + {{8{x_out[XWIDTH-1]}}, x_out};
  end

  assign acc_out = acc_q;
`else
  assign acc_out = '0;
`endif

endmodule

// File: tb/tb_dp_result_buffer.sv
// Directed and random bench for dp_result_buffer.
// Reference model is a queue of pairs plus integer accumulator.
module tb_dp_result_buffer;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [15:0] x;
    logic [7:0]  z;
  } pair_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] x_in = '0;
  logic [7:0]  z_in = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] x_out;
  logic [7:0]  z_out;
  logic        out_ready = 1'b0;
  logic [2:0]  count;
  logic        ovf;
  logic [23:0] acc_out;

  int ncmp = 0;
  int nerr = 0;

  pair_t q[$];
  bit    ovf_m = 1'b0;
  int    acc_m = 0;

  dp_result_buffer #(.XWIDTH(16), .ZWIDTH(8), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .x_in(x_in), .z_in(z_in),
    .in_ready(in_ready),
    .out_valid(out_valid), .x_out(x_out), .z_out(z_out),
    .out_ready(out_ready),
    .count(count), .ovf(ovf), .acc_out(acc_out)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [23:0] acc_e;
    logic [31:0] hx;
    logic [31:0] hz;
    int          n;
    n  = q.size();
    hx = (n != 0) ? 32'(q[0].x) : 32'd0;
    hz = (n != 0) ? 32'(q[0].z) : 32'd0;
`ifdef DP_RESULT_ACC_EN
    acc_e = acc_m[23:0];
`else
    acc_e = '0;
`endif
    chk({tag, ".count"}, 32'(count), 32'(n));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(n != DEPTH));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(n != 0));
    chk({tag, ".x_out"}, 32'(x_out), hx);
    chk({tag, ".z_out"}, 32'(z_out), hz);
    chk({tag, ".ovf"}, 32'(ovf), 32'(ovf_m));
    chk({tag, ".acc"}, 32'(acc_out), 32'(acc_e));
  endtask

  // Called at a negedge: drive, check pre-edge view, advance model over posedge.
  task automatic step(input string tag, input logic iv,
                      input logic [15:0] x, input logic [7:0] z,
                      input logic ordy);
    bit full;
    bit empty;
    in_valid  = iv;
    x_in      = x;
    z_in      = z;
    out_ready = ordy;
    #1;
    check_all(tag);
    full  = (q.size() == DEPTH);
    empty = (q.size() == 0);
    @(posedge CLK);
    if (iv && full)
      ovf_m = 1'b1;
    if (ordy && !empty) begin
      acc_m += int'($signed(q[0].x));
      void'(q.pop_front());
    end
    if (iv && !full)
      q.push_back('{x: x, z: z});
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #1;
    q.delete();
    ovf_m = 1'b0;
    acc_m = 0;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.x_out", 32'(x_out), 32'd0);
    chk("rst.z_out", 32'(z_out), 32'd0);
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.ovf", 32'(ovf), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.acc", 32'(acc_out), 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    @(negedge CLK);
    do_reset();

    // 1: single push, visible next cycle
    step("t1a", 1, 16'h0005, 8'h03, 0);
    in_valid = 1'b0;
    #1;
    chk("t1.x_out", 32'(x_out), 32'h5);
    chk("t1.z_out", 32'(z_out), 32'h3);
    chk("t1.count", 32'(count), 32'd1);
    step("t1b", 0, '0, '0, 1);

    // 2: fill, overflow, drain in order
    for (int i = 1; i <= 4; i++)
      step("t2fill", 1, 16'(i), 8'(i + 8'h10), 0);
    step("t2ovf", 1, 16'h0005, 8'h15, 0);
    #1;
    chk("t2.count", 32'(count), 32'd4);
    chk("t2.ovf", 32'(ovf), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("t2.order", 32'(x_out), 32'(i));
      step("t2pop", 0, '0, '0, 1);
    end
    #1;
    chk("t2.ovf_hold", 32'(ovf), 32'd1);

    // 3: full with simultaneous push and pop refuses the push
    for (int i = 0; i < 4; i++)
      step("t3fill", 1, 16'(16'h100 + i), 8'(i), 0);
    step("t3both", 1, 16'h0BAD, 8'hEE, 1);
    #1;
    chk("t3.count", 32'(count), 32'd3);
    chk("t3.in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++)
      step("t3drain", 0, '0, '0, 1);

    // 4: steady push/pop at count=2
    step("t4a", 1, 16'h0200, 8'h00, 0);
    step("t4b", 1, 16'h0201, 8'h01, 0);
    for (int i = 2; i < 12; i++)
      step("t4run", 1, 16'(16'h0200 + i), 8'(i), 1);
    #1;
    chk("t4.count", 32'(count), 32'd2);
    chk("t4.head", 32'(x_out), 32'h020A);
    step("t4c", 0, '0, '0, 1);
    step("t4d", 0, '0, '0, 1);

    // 5: accumulator from a fresh reset
    do_reset();
    step("t5a", 1, 16'hFFFE, 8'h01, 0);
    step("t5b", 1, 16'h0007, 8'h02, 0);
    step("t5p1", 0, '0, '0, 1);
    #1;
`ifdef DP_RESULT_ACC_EN
    chk("t5.acc1", 32'(acc_out), 32'h00FFFFFE);
`else
    chk("t5.acc1", 32'(acc_out), 32'h0);
`endif
    step("t5p2", 0, '0, '0, 1);
    #1;
`ifdef DP_RESULT_ACC_EN
    chk("t5.acc2", 32'(acc_out), 32'h00000005);
`else
    chk("t5.acc2", 32'(acc_out), 32'h0);
`endif

    // random traffic against the queue model
    for (int i = 0; i < 400; i++)
      step("rnd", 1'($urandom_range(0, 99) < 60),
           16'($urandom), 8'($urandom),
           1'($urandom_range(0, 99) < 50));

    // 6: async reset mid-stream with three entries
    do_reset();
    for (int i = 0; i < 3; i++)
      step("t6fill", 1, 16'(16'h0300 + i), 8'(i), 0);
    step("t6ovf", 0, '0, '0, 0);
    #1;
    chk("t6.pre_count", 32'(count), 32'd3);
    do_reset();
    step("t6post", 0, '0, '0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
